// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Holds the FSM state encoding, the minimum divisor and the divisor clamp.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam int CLK_DIV_MIN = 2;

  // Divisors below the minimum would give no low (or no high) phase.
  function automatic logic [31:0] clamp_div(input logic [31:0] val);
    return (val < 32'(CLK_DIV_MIN)) ? 32'(CLK_DIV_MIN) : val;
  endfunction

endpackage

// File: rtl/clk_div_prog_if.sv
// Control/status bundle of clk_div_prog: run request, divisor load/ack, divided clock outputs.
// The master is the software-facing controller; the slave is the divider.
interface clk_div_prog_if #(
  parameter int WIDTH = 16
);
  logic             en_i;
  logic [WIDTH-1:0] div_i;
  logic             div_load_i;
  logic             div_ack_o;
  logic [WIDTH-1:0] div_o;
  logic             clk_o;
  logic             tick_o;
  logic             busy_o;

  modport master (
    output en_i, div_i, div_load_i,
    input  div_ack_o, div_o, clk_o, tick_o, busy_o
  );

  modport slave (
    input  en_i, div_i, div_load_i,
    output div_ack_o, div_o, clk_o, tick_o, busy_o
  );
endinterface

// File: rtl/clk_div_shadow.sv
// Divisor shadow register: captures clamped loads and applies the latest one at a period boundary.
// The ack pulse is registered and coincides with the first cycle of the new period.
module clk_div_shadow #(
  parameter int WIDTH     = 16,
  parameter int DIV_RESET = 10
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] div_i,
  input  logic             div_load_i,
  input  logic             boundary,
  output logic [WIDTH-1:0] div_act,
  output logic             ack
);
  import clk_div_pkg::*;

  localparam logic [WIDTH-1:0] DIV_INIT = WIDTH'(clamp_div(32'(DIV_RESET)));

  logic [WIDTH-1:0] pend_div;
  logic             pend;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      pend_div <= '0;
      pend     <= 1'b0;
      div_act  <= DIV_INIT;
      ack      <= 1'b0;
    end else begin
      ack <= 1'b0;
      if (boundary && pend) begin
        div_act <= pend_div;
        ack     <= 1'b1;
        pend    <= 1'b0;
      end
      // A load on a boundary edge lands after the apply above, so it waits a full period.
      if (div_load_i) begin
        pend_div <= WIDTH'(clamp_div(32'(div_i)));
        pend     <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider with glitch-free enable/disable and boundary-aligned divisor changes.
// Define CLK_DIV_ODD50_EN to add a falling-edge stage giving exact 50% duty for odd divisors.
module clk_div_prog #(
  parameter int WIDTH     = 16,
  parameter int DIV_RESET = 10
) (
  input  logic           clk_i,
  input  logic           rst_n,
  clk_div_prog_if.slave  bus
);
  import clk_div_pkg::*;

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] next_cnt;
  logic [WIDTH-1:0] div_act;
  logic [WIDTH-1:0] high_len;
  logic             at_wrap;
  logic             boundary;
  logic             pos_q;
  logic             tick_q;
  logic             ack;

  assign at_wrap  = (cnt == div_act - WIDTH'(1));
  assign next_cnt = at_wrap ? '0 : cnt + WIDTH'(1);
  assign boundary = (state == IDLE) || at_wrap;

`ifdef CLK_DIV_ODD50_EN
  assign high_len = div_act >> 1;
`else
  assign high_len = div_act - (div_act >> 1);
`endif

  clk_div_shadow #(
    .WIDTH     (WIDTH),
    .DIV_RESET (DIV_RESET)
  ) u_shadow (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .div_i      (bus.div_i),
    .div_load_i (bus.div_load_i),
    .boundary   (boundary),
    .div_act    (div_act),
    .ack        (ack)
  );

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      pos_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt    <= '0;
          pos_q  <= 1'b0;
          tick_q <= 1'b0;
          if (bus.en_i) begin
            state  <= RUN;
            pos_q  <= 1'b1;
            tick_q <= 1'b1;
          end
        end
        RUN: begin
          cnt    <= next_cnt;
          pos_q  <= (next_cnt < high_len);
          tick_q <= at_wrap;
          if (!bus.en_i) state <= STOP;
        end
        STOP: begin
          // Only park at the period end so the low phase is never cut short.
          if (at_wrap && !bus.en_i) begin
            state  <= IDLE;
            cnt    <= '0;
            pos_q  <= 1'b0;
            tick_q <= 1'b0;
          end else begin
            cnt    <= next_cnt;
            pos_q  <= (next_cnt < high_len);
            tick_q <= at_wrap;
            if (bus.en_i) state <= RUN;
          end
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          pos_q  <= 1'b0;
          tick_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef CLK_DIV_ODD50_EN
  logic neg_q;

  // Stretches the high phase by half a source cycle, odd divisors only.
  always_ff @(negedge clk_i or negedge rst_n) begin
    if (!rst_n) neg_q <= 1'b0;
    else        neg_q <= pos_q & div_act[0];
  end

  assign bus.clk_o = pos_q | neg_q;
`else
  assign bus.clk_o = pos_q;
`endif

  assign bus.tick_o    = tick_q;
  assign bus.div_ack_o = ack;
  assign bus.div_o     = div_act;
  assign bus.busy_o    = (state != IDLE);

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Runtime-programmable clock divider. It generates a divided clock `clk_o` and a matching one-cycle strobe `tick_o` from `clk_i`. The divisor can be changed on the fly, and changes take effect only at period boundaries. Enable and disable are glitch-free, so no runt pulses appear on `clk_o`. It is the parametrised successor to the fixed-ratio divider and serves peripheral clocks (UART, SPI, PWM) whose rate is set by software.

## Interface
Parameters:
- `WIDTH`, 16: width of the divisor and the counter.
- `DIV_RESET`, 10: active divisor after reset. Clamped to ≥2.

Ports:
- `clk_i`, input, 1: source clock.
- `rst_n`, input, 1: asynchronous reset, active-low.
- `en_i`, input, 1: run request, level-sensitive.
- `div_i`, input, WIDTH: new divisor N.
- `div_load_i`, input, 1: one-cycle pulse that captures `div_i`.
- `div_ack_o`, output, 1: one-cycle pulse when the captured divisor becomes active.
- `div_o`, output, WIDTH: currently active divisor.
- `clk_o`, output, 1: divided clock.
- `tick_o`, output, 1: one-cycle strobe, high in the cycle `clk_o` rises.
- `busy_o`, output, 1: high while state ≠ IDLE.

## Operation
- Period is N `clk_i` cycles. The phase counter `cnt` runs 0..N-1 and wraps to 0.
- High phase H: ceil(N/2) cycles without the macro; floor(N/2) registered cycles with the macro (see Configuration).
- Divisor rules:
  - N of 0 or 1 is clamped to 2 at capture.
  - Divisor arithmetic is unsigned WIDTH bits. `cnt` never exceeds N-1.
- State machine: IDLE, RUN, STOP.
  - IDLE: `cnt`=0, `clk_o`=0. If `en_i`=1, go to RUN and register `cnt`=0, `clk_o`=1, `tick_o`=1.
  - RUN: next_cnt = (`cnt`==N-1) ? 0 : `cnt`+1. Register `clk_o` = (next_cnt < H) and `tick_o` = (next_cnt==0). If `en_i`=0, go to STOP.
  - STOP: keep counting. When next_cnt==0, go to IDLE with `clk_o`=0 and `tick_o`=0. If `en_i` returns to 1 while in STOP, go back to RUN with no phase disturbance.
- Divisor load:
  - `div_load_i` writes the clamped `div_i` into a pending register and sets `pend`.
  - In RUN or STOP, the pending value is applied on the cycle where next_cnt==0. `div_ack_o` pulses in that same cycle and `pend` clears.
  - In IDLE, the pending value is applied on the next edge and `div_ack_o` pulses then.
  - A load while `pend`=1 overwrites the pending value. Only the last value is acked, once.
  - A load in the same cycle as a boundary is captured but not applied until the following boundary.
- Reset mid-operation: all state clears immediately. The active divisor reverts to DIV_RESET and any pending load is discarded.

## Timing
- Reset values:
  - `clk_o`=0, `tick_o`=0, `div_ack_o`=0, `busy_o`=0.
  - `div_o` = clamped DIV_RESET.
  - `cnt`=0, state IDLE, `pend`=0.
- Latencies:
  - `en_i` sampled high in IDLE → `clk_o` and `tick_o` high on the next edge (1 cycle).
  - Divisor change → first period with the new N begins exactly at the `div_ack_o` cycle.
- All outputs are registered. `clk_o` has no combinational path from `clk_i`, except the macro's OR stage.

## Configuration
- `CLK_DIV_ODD50_EN` defined:
  - A falling-edge flop samples the registered high signal.
  - For odd N, `clk_o` = pos_q | neg_q, which gives exactly 50% duty (N/2 cycles high).
  - For even N the neg path is disabled and H = N/2.
  - The neg flop is also reset by `rst_n`.
- Undefined:
  - Posedge logic only. Odd N gives (N+1)/2 cycles high and (N-1)/2 low.
- `tick_o` timing is identical in both builds.

## Structure
- Package `clk_div_pkg`:
  - State enum (IDLE, RUN, STOP).
  - `CLK_DIV_MIN` = 2.
  - Clamp function.
- Sub-module `clk_div_shadow`: pending register, `pend` flag, clamp, apply/ack logic. It takes a boundary input and produces the active divisor.
- The top level holds the FSM, the counter and the output flops.

## Test plan
- Reset with DIV_RESET=10, `en_i`=1 → `clk_o` high 5 / low 5, `tick_o` every 10 cycles, first rise 1 cycle after enable.
- N=7 → without macro 4 high / 3 low. With `CLK_DIV_ODD50_EN`, 3.5 high / 3.5 low (check both edges).
- Load `div_i`=4 at `cnt`=3 of a 10-cycle period → `div_ack_o` at the wrap, that period stays 10, next periods are 4. Load `div_i`=0 → `div_o`=2, period 2.
- Two loads (6, then 8) before a boundary → single ack, `div_o`=8. Load coincident with boundary → applied one period later.
- `en_i` dropped at `cnt`=2 (N=10) → period completes, then IDLE with `clk_o`=0 and no runt. `en_i` re-raised during STOP → continuous output.
- `rst_n` asserted mid-high phase → `clk_o`=0 immediately, pending load discarded, `div_o`=DIV_RESET.
